// File: rtl/spi_tx_serial_pkg.sv
// Shared types and constants for the SPI slave telemetry transmitter.
package spi_tx_serial_pkg;

    localparam int unsigned WORD_W_DEF = 33;
    localparam int unsigned CNT_W      = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with a delay flop giving single-cycle rise/fall strobes.
module spi_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Reset to the line's idle level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall_c = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_tx_serial.sv
// SPI mode-0 slave transmitter returning one telemetry word per chip-select frame.
// Optional macro SPI_TX_PARITY_EN appends an even-parity bit after the word LSB.
module spi_tx_serial
    import spi_tx_serial_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_W_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs,
    input  logic [WORD_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              spi_miso,
    output logic              frame_done,
    output logic              frame_abort,
    output logic              stale
);

`ifdef SPI_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = WORD_W + 1;
`else
    localparam int unsigned FRAME_BITS = WORD_W;
`endif
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    logic sck_rise_c, sck_fall_c, cs_rise_c, cs_fall_c;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (spi_clk),
        .rise_c (sck_rise_c),
        .fall_c (sck_fall_c)
    );

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .din    (spi_cs),
        .rise_c (cs_rise_c),
        .fall_c (cs_fall_c)
    );

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [WORD_W-1:0] sh_q, sh_n;
    logic [WORD_W-1:0] cur_q, cur_n;
    logic [WORD_W-1:0] hold_q, hold_n;
    logic [WORD_W-1:0] last_q, last_n;
    logic              hold_full_q, hold_full_n;
    logic              miso_q, miso_n;
    logic              ready_q, ready_n;
    logic              done_q, done_n;
    logic              abort_q, abort_n;
    logic              stale_q, stale_n;
    logic [WORD_W-1:0] load_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            cur_q       <= '0;
            hold_q      <= '0;
            last_q      <= '0;
            hold_full_q <= 1'b0;
            miso_q      <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            stale_q     <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            sh_q        <= sh_n;
            cur_q       <= cur_n;
            hold_q      <= hold_n;
            last_q      <= last_n;
            hold_full_q <= hold_full_n;
            miso_q      <= miso_n;
            ready_q     <= ready_n;
            done_q      <= done_n;
            abort_q     <= abort_n;
            stale_q     <= stale_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        sh_n        = sh_q;
        cur_n       = cur_q;
        hold_n      = hold_q;
        last_n      = last_q;
        hold_full_n = hold_full_q;
        miso_n      = miso_q;
        done_n      = 1'b0;
        abort_n     = 1'b0;
        stale_n     = 1'b0;
        load_word   = '0;

        case (state_q)
            ST_IDLE: begin
                miso_n = 1'b0;
                if (cs_fall_c) begin
                    // No fresh word: repeat the last completed word and flag it.
                    if (hold_full_q) begin
                        load_word   = hold_q;
                        hold_full_n = 1'b0;
                    end else begin
                        load_word = last_q;
                        stale_n   = 1'b1;
                    end
                    sh_n    = load_word;
                    cur_n   = load_word;
                    miso_n  = load_word[WORD_W-1];
                    cnt_n   = '0;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_c) begin
                    abort_n = 1'b1;
                    miso_n  = 1'b0;
                    state_n = ST_IDLE;
                end else if (sck_rise_c) begin
                    cnt_n = cnt_q + CNT_W'(1);
                    if (cnt_n == FRAME_CNT) begin
                        last_n  = cur_q;
                        miso_n  = 1'b0;
                        state_n = ST_TAIL;
                    end
                end else if (sck_fall_c && (cnt_q < FRAME_CNT)) begin
`ifdef SPI_TX_PARITY_EN
                    if (cnt_q == CNT_W'(WORD_W)) begin
                        miso_n = ^cur_q;
                    end else begin
                        sh_n   = {sh_q[WORD_W-2:0], 1'b0};
                        miso_n = sh_q[WORD_W-2];
                    end
`else
                    sh_n   = {sh_q[WORD_W-2:0], 1'b0};
                    miso_n = sh_q[WORD_W-2];
`endif
                end
            end
            ST_TAIL: begin
                miso_n = 1'b0;
                if (cs_rise_c) begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                miso_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase

        // Acceptance sees the pre-load flag, so a same-cycle push is held for the next frame.
        if (tx_valid && !hold_full_q) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
        end
    end

    assign ready_n     = ~hold_full_n;
    assign tx_ready    = ready_q;
    assign spi_miso    = miso_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_spi_tx_serial.sv
// Self-checking bench for spi_tx_serial: directed frames plus randomized frames vs. a word-level model.
module tb_spi_tx_serial;

    localparam int unsigned WORD_W = 33;
`ifdef SPI_TX_PARITY_EN
    localparam int FRAME = WORD_W + 1;
`else
    localparam int FRAME = WORD_W;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_clk;
    logic              spi_cs;
    logic [WORD_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              spi_miso;
    logic              frame_done;
    logic              frame_abort;
    logic              stale;

    spi_tx_serial #(.WORD_W(WORD_W), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_clk     (spi_clk),
        .spi_cs      (spi_cs),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .spi_miso    (spi_miso),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int stale_cnt = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1)  done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
        if (stale === 1'b1)       stale_cnt++;
    end

    // Word-level model: one-deep holding slot, last completed word, pending stalled push.
    logic [WORD_W-1:0] m_hold = '0;
    logic [WORD_W-1:0] m_last = '0;
    logic              m_full = 1'b0;
    logic              pend = 1'b0;
    logic [WORD_W-1:0] pend_word = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [WORD_W-1:0] w, input int k);
        if (k <= int'(WORD_W)) return w[WORD_W-k];
`ifdef SPI_TX_PARITY_EN
        if (k == int'(WORD_W) + 1) return ^w;
`endif
        return 1'b0;
    endfunction

    function automatic logic [WORD_W-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return WORD_W'(r);
    endfunction

    task automatic push(input logic [WORD_W-1:0] w);
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("push_ready", 64'(tx_ready), 64'(1));
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        m_hold   = w;
        m_full   = 1'b1;
        chk("push_taken", 64'(tx_ready), 64'(0));
    endtask

    task automatic run_frame(input int nsck, input string tag);
        logic [WORD_W-1:0] w;
        logic              exp_st;
        int                d0, a0, s0;
        d0 = done_cnt;
        a0 = abort_cnt;
        s0 = stale_cnt;
        if (m_full) begin
            w      = m_hold;
            m_full = 1'b0;
            exp_st = 1'b0;
        end else begin
            w      = m_last;
            exp_st = 1'b1;
        end
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (10) @(negedge clk);
        if (pend) begin
            m_hold   = pend_word;
            m_full   = 1'b1;
            pend     = 1'b0;
            tx_valid = 1'b0;
        end
        chk({tag, " ready"}, 64'(tx_ready), 64'(!m_full));
        for (int k = 1; k <= nsck; k++) begin
            spi_clk = 1'b1;
            chk($sformatf("%s bit%0d", tag, k), 64'(spi_miso), 64'(exp_bit(w, k)));
            repeat (5) @(negedge clk);
            spi_clk = 1'b0;
            repeat (5) @(negedge clk);
        end
        spi_cs = 1'b1;
        repeat (10) @(negedge clk);
        if (nsck >= FRAME) begin
            m_last = w;
            chk({tag, " done"}, 64'(done_cnt - d0), 64'(1));
            chk({tag, " abort"}, 64'(abort_cnt - a0), 64'(0));
        end else begin
            chk({tag, " done"}, 64'(done_cnt - d0), 64'(0));
            chk({tag, " abort"}, 64'(abort_cnt - a0), 64'(1));
        end
        chk({tag, " stale"}, 64'(stale_cnt - s0), 64'(exp_st));
        chk({tag, " miso_idle"}, 64'(spi_miso), 64'(0));
    endtask

    initial begin
        int d0, a0;
        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_cs   = 1'b1;
        tx_data  = '0;
        tx_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst miso", 64'(spi_miso), 64'(0));
        chk("rst ready", 64'(tx_ready), 64'(1));
        chk("rst done", 64'(frame_done), 64'(0));
        chk("rst abort", 64'(frame_abort), 64'(0));
        chk("rst stale", 64'(stale), 64'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst pulses", 64'(done_cnt + abort_cnt + stale_cnt), 64'(0));

        push(33'h1_2345_6789);
        run_frame(33, "basic");
        run_frame(33, "repeat");

        push(rnd_word());
        run_frame(10, "abort");
        run_frame(33, "resend");

        // Second word stalls while the slot is full, then lands at the next frame start.
        push(rnd_word());
        pend_word = rnd_word();
        tx_data   = pend_word;
        tx_valid  = 1'b1;
        pend      = 1'b1;
        repeat (5) @(negedge clk);
        chk("stall ready", 64'(tx_ready), 64'(0));
        run_frame(33, "stallA");
        run_frame(33, "stallB");

        run_frame(40, "over");

        push(33'h0_0000_0007);
        run_frame(FRAME, "par7");
        push(33'h0_0000_0003);
        run_frame(FRAME, "par3");

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 1) push(rnd_word());
            run_frame(int'($urandom_range(5, 40)), $sformatf("rnd%0d", i));
        end

        // Reset mid-frame: frame discarded silently, state cleared.
        push(rnd_word());
        d0 = done_cnt;
        a0 = abort_cnt;
        spi_cs = 1'b0;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            spi_clk = 1'b1;
            repeat (5) @(negedge clk);
            spi_clk = 1'b0;
            repeat (5) @(negedge clk);
        end
        rst     = 1'b1;
        spi_cs  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        m_full = 1'b0;
        m_last = '0;
        chk("midrst abort", 64'(abort_cnt - a0), 64'(0));
        chk("midrst done", 64'(done_cnt - d0), 64'(0));
        chk("midrst miso", 64'(spi_miso), 64'(0));
        chk("midrst ready", 64'(tx_ready), 64'(1));
        run_frame(33, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
